// File: rtl/hour_set_12h_if.sv
// Commit handshake carrying the 24-hour packed-BCD hour to the timekeeping core.
// Valid is held with the data frozen until ready is seen.
interface hour_set_12h_if;
  logic       load_vld;
  logic       load_rdy;
  logic [7:0] hour24_dat;

  modport master (output load_vld, output hour24_dat, input load_rdy);
  modport slave  (input load_vld, input hour24_dat, output load_rdy);
endinterface

// File: rtl/hour_set_12h.sv
// 12-hour button entry (01..12 + AM/PM) committing a 24-hour BCD hour; edits show 1 cycle after a button rises,
// hour24 follows 1 cycle later; a commit holds valid and freezes hour24 until the core is ready.
module hour_set_12h #(
  parameter int REPEAT_DLY  = 50_000_000,
  parameter int REPEAT_RATE = 10_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en_set,
  input  logic [7:0]            i_cur_hour24,
  input  logic                  i_btn_up,
  input  logic                  i_btn_down,
  input  logic                  i_btn_ampm,
  input  logic                  i_btn_commit,
  hour_set_12h_if.master        o_load,
  output logic [7:0]            o_hour12_bcd,
  output logic                  o_pm,
  output logic                  o_busy
);

  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_EDIT, S_LOAD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_hour12;
  logic [7:0]    w_hour12_nxt;
  logic          r_pm;
  logic          w_pm_nxt;
  logic [7:0]    r_hour24;
  logic          r_load_vld;
  logic          w_load_vld_nxt;
  logic          r_up_q;
  logic          r_dn_q;
  logic          r_ampm_q;
  logic          r_commit_q;
  logic [CW-1:0] r_rpt_cnt;
  logic          r_rpt_on;

  logic          w_edge_up;
  logic          w_edge_dn;
  logic          w_edge_ampm;
  logic          w_edge_commit;
  logic          w_one_held;
  logic          w_rpt_step;
  logic          w_step_up;
  logic          w_step_dn;
  logic          w_inc;
  logic          w_dec;
  logic          w_cur_ok;
  logic [8:0]    w_cap;

  function automatic logic [4:0] bcd2bin(input logic [7:0] b);
    return 5'(b[7:4]) * 5'd10 + 5'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [4:0] v);
    if (v >= 5'd20)      return {4'd2, 4'(v - 5'd20)};
    else if (v >= 5'd10) return {4'd1, 4'(v - 5'd10)};
    else                 return {4'd0, 4'(v)};
  endfunction

  function automatic logic [7:0] to24(input logic [7:0] h12, input logic pm);
    logic [4:0] b;
    b = bcd2bin(h12);
    if (b == 5'd12) return pm ? 8'h12 : 8'h00;
    else            return bin2bcd(pm ? b + 5'd12 : b);
  endfunction

  // Returns {pm, hour12}; only meaningful for a validated input.
  function automatic logic [8:0] to12(input logic [7:0] h24);
    logic [4:0] b;
    b = bcd2bin(h24);
    if (b == 5'd0)       return {1'b0, 8'h12};
    else if (b < 5'd12)  return {1'b0, h24};
    else if (b == 5'd12) return {1'b1, 8'h12};
    else                 return {1'b1, bin2bcd(b - 5'd12)};
  endfunction

  function automatic logic [7:0] inc12(input logic [7:0] h);
    logic [4:0] b;
    b = bcd2bin(h);
    return (b >= 5'd12) ? 8'h01 : bin2bcd(b + 5'd1);
  endfunction

  function automatic logic [7:0] dec12(input logic [7:0] h);
    logic [4:0] b;
    b = bcd2bin(h);
    return (b <= 5'd1) ? 8'h12 : bin2bcd(b - 5'd1);
  endfunction

  assign w_edge_up     = i_btn_up     & ~r_up_q;
  assign w_edge_dn     = i_btn_down   & ~r_dn_q;
  assign w_edge_ampm   = i_btn_ampm   & ~r_ampm_q;
  assign w_edge_commit = i_btn_commit & ~r_commit_q;

  assign w_cur_ok = (i_cur_hour24[7:4] <= 4'd2) && (i_cur_hour24[3:0] <= 4'd9) &&
                    (i_cur_hour24 <= 8'h23);
  assign w_cap    = to12(i_cur_hour24);

  // Repeat fires only on a steady single-button hold, never on the press edge itself.
  assign w_one_held = i_btn_up ^ i_btn_down;
  assign w_rpt_step = (r_state == S_EDIT) && w_one_held && !(w_edge_up || w_edge_dn) &&
                      ((!r_rpt_on && r_rpt_cnt == CW'(REPEAT_DLY)) ||
                       ( r_rpt_on && r_rpt_cnt == CW'(REPEAT_RATE)));
  assign w_step_up  = w_edge_up | (w_rpt_step & i_btn_up);
  assign w_step_dn  = w_edge_dn | (w_rpt_step & i_btn_down);
  assign w_inc      = w_step_up & ~w_step_dn;
  assign w_dec      = w_step_dn & ~w_step_up;

  always_comb begin
    w_state_nxt    = r_state;
    w_hour12_nxt   = r_hour12;
    w_pm_nxt       = r_pm;
    w_load_vld_nxt = r_load_vld;
    case (r_state)
      S_IDLE: begin
        if (i_en_set) begin
          w_state_nxt  = S_EDIT;
          w_hour12_nxt = w_cur_ok ? w_cap[7:0] : 8'h12;
          w_pm_nxt     = w_cur_ok ? w_cap[8]   : 1'b0;
        end
      end
      S_EDIT: begin
        if (!i_en_set) begin
          w_state_nxt = S_IDLE;
        end else if (w_edge_commit) begin
          w_state_nxt    = S_LOAD;
          w_load_vld_nxt = 1'b1;
        end else begin
          if (w_inc)       w_hour12_nxt = inc12(r_hour12);
          else if (w_dec)  w_hour12_nxt = dec12(r_hour12);
          if (w_edge_ampm) w_pm_nxt     = ~r_pm;
        end
      end
      S_LOAD: begin
        if (o_load.load_rdy) begin
          w_state_nxt    = S_IDLE;
          w_load_vld_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_hour12   <= 8'h12;
      r_pm       <= 1'b0;
      r_hour24   <= 8'h00;
      r_load_vld <= 1'b0;
      r_up_q     <= 1'b0;
      r_dn_q     <= 1'b0;
      r_ampm_q   <= 1'b0;
      r_commit_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hour12   <= w_hour12_nxt;
      r_pm       <= w_pm_nxt;
      r_load_vld <= w_load_vld_nxt;
      r_up_q     <= i_btn_up;
      r_dn_q     <= i_btn_down;
      r_ampm_q   <= i_btn_ampm;
      r_commit_q <= i_btn_commit;
      if (r_state != S_LOAD) r_hour24 <= to24(r_hour12, r_pm);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rpt_cnt <= '0;
      r_rpt_on  <= 1'b0;
    end else if (r_state != S_EDIT || !w_one_held) begin
      r_rpt_cnt <= '0;
      r_rpt_on  <= 1'b0;
    end else if (w_edge_up || w_edge_dn) begin
      r_rpt_cnt <= CW'(1);
      r_rpt_on  <= 1'b0;
    end else if (w_rpt_step) begin
      r_rpt_cnt <= CW'(1);
      r_rpt_on  <= 1'b1;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + CW'(1);
    end
  end

  assign o_load.load_vld   = r_load_vld;
  assign o_load.hour24_dat = r_hour24;
  assign o_hour12_bcd      = r_hour12;
  assign o_pm              = r_pm;
  assign o_busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_hour_set_12h.sv
// Directed bench for hour_set_12h with short repeat timing.
module tb_hour_set_12h;

  logic       clk;
  logic       rst_n;
  logic       en_set;
  logic [7:0] cur_hour24;
  logic       btn_up;
  logic       btn_down;
  logic       btn_ampm;
  logic       btn_commit;
  logic [7:0] hour12_bcd;
  logic       pm;
  logic       busy;
  int         total;
  int         bad;

  hour_set_12h_if u_if ();

  hour_set_12h #(.REPEAT_DLY(4), .REPEAT_RATE(2)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en_set     (en_set),
    .i_cur_hour24 (cur_hour24),
    .i_btn_up     (btn_up),
    .i_btn_down   (btn_down),
    .i_btn_ampm   (btn_ampm),
    .i_btn_commit (btn_commit),
    .o_load       (u_if),
    .o_hour12_bcd (hour12_bcd),
    .o_pm         (pm),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic enter(input logic [7:0] h24);
    cur_hour24 = h24;
    en_set     = 1'b1;
    tick();
  endtask

  task automatic leave();
    en_set = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0; en_set = 1'b0; cur_hour24 = 8'h00;
    btn_up = 1'b0; btn_down = 1'b0; btn_ampm = 1'b0; btn_commit = 1'b0;
    u_if.load_rdy = 1'b0;
    tick(); tick();
    chk("rst_h12",  hour12_bcd,      8'h12);
    chk("rst_pm",   pm,              1'b0);
    chk("rst_h24",  u_if.hour24_dat, 8'h00);
    chk("rst_vld",  u_if.load_vld,   1'b0);
    chk("rst_busy", busy,            1'b0);

    // Entry with a PM hour
    rst_n = 1'b1;
    enter(8'h17);
    chk("t1_h12",  hour12_bcd, 8'h05);
    chk("t1_pm",   pm,         1'b1);
    chk("t1_busy", busy,       1'b1);
    tick();
    chk("t1_h24",  u_if.hour24_dat, 8'h17);

    // Up across 11->12->01 and down across 01->12, all AM
    leave();
    enter(8'h11);
    chk("t2_h12_in", hour12_bcd, 8'h11);
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    chk("t2_up_h12", hour12_bcd, 8'h12);
    tick();
    chk("t2_up_h24", u_if.hour24_dat, 8'h00);
    btn_up = 1'b1; tick(); btn_up = 1'b0;
    chk("t2_wrap_h12", hour12_bcd, 8'h01);
    chk("t2_wrap_pm",  pm,         1'b0);
    btn_down = 1'b1; tick(); btn_down = 1'b0;
    chk("t2_dn_h12", hour12_bcd, 8'h12);
    tick();
    chk("t2_dn_h24", u_if.hour24_dat, 8'h00);

    // AM/PM toggle and a stalled commit
    leave();
    enter(8'h08);
    btn_ampm = 1'b1; tick(); btn_ampm = 1'b0;
    chk("t3_pm", pm, 1'b1);
    tick();
    chk("t3_h24", u_if.hour24_dat, 8'h20);
    btn_commit = 1'b1; tick(); btn_commit = 1'b0;
    chk("t3_vld_rise", u_if.load_vld, 1'b1);
    en_set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_up = (i == 1);
      tick();
      chk("t3_vld_hold", u_if.load_vld,   1'b1);
      chk("t3_h24_hold", u_if.hour24_dat, 8'h20);
    end
    btn_up = 1'b0;
    chk("t3_h12_ign", hour12_bcd, 8'h08);
    u_if.load_rdy = 1'b1; tick(); u_if.load_rdy = 1'b0;
    chk("t3_vld_done",  u_if.load_vld, 1'b0);
    chk("t3_busy_done", busy,          1'b0);

    // Invalid entry, simultaneous up/down, commit beating up
    enter(8'h3A);
    chk("t4_inv_h12", hour12_bcd, 8'h12);
    chk("t4_inv_pm",  pm,         1'b0);
    btn_up = 1'b1; btn_down = 1'b1; tick(); btn_up = 1'b0; btn_down = 1'b0;
    chk("t4_updn", hour12_bcd, 8'h12);
    tick();
    btn_commit = 1'b1; btn_up = 1'b1; tick(); btn_commit = 1'b0; btn_up = 1'b0;
    chk("t4_cmt_vld", u_if.load_vld,   1'b1);
    chk("t4_cmt_h12", hour12_bcd,      8'h12);
    chk("t4_cmt_h24", u_if.hour24_dat, 8'h00);
    u_if.load_rdy = 1'b1; tick(); u_if.load_rdy = 1'b0;
    chk("t4_cmt_done", u_if.load_vld, 1'b0);

    // Auto-repeat: steps at press, +4, +6, +8 cycles
    enter(8'h01);
    chk("t5_h12_in", hour12_bcd, 8'h01);
    btn_up = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    btn_up = 1'b0;
    chk("t5_rpt_h12", hour12_bcd, 8'h05);
    tick();
    chk("t5_rpt_h24", u_if.hour24_dat, 8'h05);

    // Noon, 23h and a combined ampm+up step 11 PM -> 12 AM
    leave();
    enter(8'h12);
    chk("t5_noon_pm", pm, 1'b1);
    tick();
    chk("t5_noon_h24", u_if.hour24_dat, 8'h12);
    leave();
    enter(8'h24);
    chk("t5_inv24_h12", hour12_bcd, 8'h12);
    chk("t5_inv24_pm",  pm,         1'b0);
    leave();
    enter(8'h23);
    chk("t5_23_h12", hour12_bcd, 8'h11);
    tick();
    chk("t5_23_h24", u_if.hour24_dat, 8'h23);
    btn_ampm = 1'b1; btn_up = 1'b1; tick(); btn_ampm = 1'b0; btn_up = 1'b0;
    chk("t5_comb_h12", hour12_bcd, 8'h12);
    chk("t5_comb_pm",  pm,         1'b0);
    tick();
    chk("t5_comb_h24", u_if.hour24_dat, 8'h00);

    // Abort, then reset during LOAD
    leave();
    chk("t6_abort_busy", busy,          1'b0);
    chk("t6_abort_vld",  u_if.load_vld, 1'b0);
    chk("t6_abort_h12",  hour12_bcd,    8'h12);
    enter(8'h07);
    btn_commit = 1'b1; tick(); btn_commit = 1'b0;
    chk("t6_load_vld", u_if.load_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld",  u_if.load_vld, 1'b0);
    chk("t6_rst_h12",  hour12_bcd,    8'h12);
    chk("t6_rst_busy", busy,          1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
